// File: rtl/wb_intercon_wdt_pkg.sv
// Shared definitions for the Wishbone interconnect stage with access watchdog.
// Holds the FSM state encoding, the default error read data and common widths.
package wb_intercon_wdt_pkg;

    localparam int unsigned WBI_DATA_WIDTH = 8;
    localparam int unsigned WBI_CNT_WIDTH  = 8;

    localparam logic [WBI_DATA_WIDTH-1:0] WBI_ERR_DATA = 8'hDE;
    localparam logic [WBI_CNT_WIDTH-1:0]  WBI_ERR_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        WBI_IDLE   = 2'd0,
        WBI_ACTIVE = 2'd1,
        WBI_DONE   = 2'd2
    } wbi_state_e;

endpackage

// File: rtl/wb_intercon_wdt_wdt_counter.sv
// Watchdog counter: 8-bit up-counter with synchronous clear and count enable.
// Ports: wb_clk_i/wb_rst_i clock and sync active-high reset; clr zeroes the
// count; en increments it; match_c is high while the count equals MATCH_VAL.
module wb_wdt_counter
    import wb_intercon_wdt_pkg::*;
#(
    parameter logic [WBI_CNT_WIDTH-1:0] MATCH_VAL = 8'd254
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clr,
    input  logic en,
    output logic match_c
);

    logic [WBI_CNT_WIDTH-1:0] cnt_q;
    logic [WBI_CNT_WIDTH-1:0] cnt_d;

    // Clear has priority over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + WBI_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_c = (cnt_q == MATCH_VAL);

endmodule

// File: rtl/wb_intercon_wdt.sv
// Wishbone interconnect stage: decodes the top address bits into one-hot slave
// strobes, forwards one registered transaction at a time, muxes the selected
// slave's read data/ack back, and terminates any access not acked within
// TIMEOUT cycles with an error ack (ERR_DATA), logging count and address.
// Ports: wb_* master side; s_* slave side (s_stb_o also serves as slave cyc);
// bus_err pulses on timeout/unpopulated access; err_count saturates at 255;
// err_adr holds the address of the most recent errored access.
module wb_intercon_wdt
    import wb_intercon_wdt_pkg::*;
#(
    parameter int unsigned                     SEL_WIDTH  = 1,
    parameter int unsigned                     ADR_WIDTH  = 5,
    parameter logic [(1 << SEL_WIDTH)-1:0]     SLAVE_MASK = '1,
    parameter int unsigned                     TIMEOUT    = 255,
    parameter logic [WBI_DATA_WIDTH-1:0]       ERR_DATA   = WBI_ERR_DATA
) (
    input  logic                                         wb_clk_i,
    input  logic                                         wb_rst_i,
    input  logic                                         wb_cyc_i,
    input  logic                                         wb_stb_i,
    input  logic                                         wb_we_i,
    input  logic [ADR_WIDTH-1:0]                         wb_adr_i,
    input  logic [WBI_DATA_WIDTH-1:0]                    wb_dat_i,
    output logic [WBI_DATA_WIDTH-1:0]                    wb_dat_o,
    output logic                                         wb_ack_o,
    output logic [(1 << SEL_WIDTH)-1:0]                  s_stb_o,
    output logic                                         s_we_o,
    output logic [ADR_WIDTH-SEL_WIDTH-1:0]               s_adr_o,
    output logic [WBI_DATA_WIDTH-1:0]                    s_dat_o,
    input  logic [WBI_DATA_WIDTH*(1 << SEL_WIDTH)-1:0]   s_dat_i,
    input  logic [(1 << SEL_WIDTH)-1:0]                  s_ack_i,
    output logic                                         bus_err,
    output logic [WBI_CNT_WIDTH-1:0]                     err_count,
    output logic [ADR_WIDTH-1:0]                         err_adr
);

    localparam int unsigned NUM_SLAVES = 1 << SEL_WIDTH;
    localparam int unsigned SADR_WIDTH = ADR_WIDTH - SEL_WIDTH;
    localparam logic [WBI_CNT_WIDTH-1:0] WDT_LAST = WBI_CNT_WIDTH'(TIMEOUT - 1);

    wbi_state_e                 state_q, state_d;
    logic [SEL_WIDTH-1:0]       sel_q, sel_d;
    logic [NUM_SLAVES-1:0]      stb_q, stb_d;
    logic                       we_q, we_d;
    logic [SADR_WIDTH-1:0]      sadr_q, sadr_d;
    logic [WBI_DATA_WIDTH-1:0]  sdat_q, sdat_d;
    logic [WBI_DATA_WIDTH-1:0]  rdat_q, rdat_d;
    logic                       ack_q, ack_d;
    logic                       err_q, err_d;
    logic [WBI_CNT_WIDTH-1:0]   ecnt_q, ecnt_d;
    logic [ADR_WIDTH-1:0]       eadr_q, eadr_d;

    logic [SEL_WIDTH-1:0]       sel_in_c;
    logic                       populated_c;
    logic                       sel_ack_c;
    logic [WBI_DATA_WIDTH-1:0]  sel_dat_c;
    logic                       cnt_clr_c;
    logic                       cnt_en_c;
    logic                       wdt_match_c;

    wb_wdt_counter #(
        .MATCH_VAL (WDT_LAST)
    ) u_wdt (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .clr       (cnt_clr_c),
        .en        (cnt_en_c),
        .match_c   (wdt_match_c)
    );

    // Slot decode for the incoming address and ack/data mux for the latched slot.
    always_comb begin
        sel_in_c    = wb_adr_i[ADR_WIDTH-1 -: SEL_WIDTH];
        populated_c = 1'b0;
        sel_ack_c   = 1'b0;
        sel_dat_c   = '0;
        for (int unsigned n = 0; n < NUM_SLAVES; n++) begin
            if (SEL_WIDTH'(n) == sel_in_c) begin
                populated_c = SLAVE_MASK[n];
            end
            if (SEL_WIDTH'(n) == sel_q) begin
                sel_ack_c = s_ack_i[n];
                sel_dat_c = s_dat_i[n*WBI_DATA_WIDTH +: WBI_DATA_WIDTH];
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        stb_d     = stb_q;
        we_d      = we_q;
        sadr_d    = sadr_q;
        sdat_d    = sdat_q;
        rdat_d    = rdat_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        ecnt_d    = ecnt_q;
        eadr_d    = eadr_q;
        cnt_clr_c = 1'b0;
        cnt_en_c  = 1'b0;

        case (state_q)
            WBI_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    sel_d  = sel_in_c;
                    we_d   = wb_we_i;
                    sadr_d = wb_adr_i[SADR_WIDTH-1:0];
                    sdat_d = wb_dat_i;
                    if (populated_c) begin
                        stb_d     = NUM_SLAVES'(1) << sel_in_c;
                        cnt_clr_c = 1'b1;
                        state_d   = WBI_ACTIVE;
                    end else begin
                        // Unpopulated slot: error-ack without touching any slave.
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        rdat_d  = ERR_DATA;
                        ecnt_d  = (ecnt_q == WBI_ERR_MAX) ? ecnt_q : ecnt_q + WBI_CNT_WIDTH'(1);
                        eadr_d  = wb_adr_i;
                        state_d = WBI_DONE;
                    end
                end
            end
            WBI_ACTIVE: begin
                // A slave ack on the last watchdog cycle takes precedence.
                if (sel_ack_c) begin
                    stb_d   = '0;
                    rdat_d  = sel_dat_c;
                    ack_d   = 1'b1;
                    state_d = WBI_DONE;
                end else if (wdt_match_c) begin
                    stb_d   = '0;
                    rdat_d  = ERR_DATA;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    ecnt_d  = (ecnt_q == WBI_ERR_MAX) ? ecnt_q : ecnt_q + WBI_CNT_WIDTH'(1);
                    eadr_d  = {sel_q, sadr_q};
                    state_d = WBI_DONE;
                end else begin
                    cnt_en_c = 1'b1;
                end
            end
            WBI_DONE: begin
                // Wait for the master to release its strobe so one strobe = one access.
                if (!wb_stb_i) begin
                    state_d = WBI_IDLE;
                end
            end
            default: begin
                state_d = WBI_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= WBI_IDLE;
            sel_q   <= '0;
            stb_q   <= '0;
            we_q    <= 1'b0;
            sadr_q  <= '0;
            sdat_q  <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            ecnt_q  <= '0;
            eadr_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sadr_q  <= sadr_d;
            sdat_q  <= sdat_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
            eadr_q  <= eadr_d;
        end
    end

    assign wb_dat_o  = rdat_q;
    assign wb_ack_o  = ack_q;
    assign s_stb_o   = stb_q;
    assign s_we_o    = we_q;
    assign s_adr_o   = sadr_q;
    assign s_dat_o   = sdat_q;
    assign bus_err   = err_q;
    assign err_count = ecnt_q;
    assign err_adr   = eadr_q;

endmodule

// File: tb/tb_wb_intercon_wdt.sv
// Directed bench for wb_intercon_wdt. Instance a: all slots populated,
// TIMEOUT=4. Instance b: only slot 0 populated, default TIMEOUT.
module tb_wb_intercon_wdt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance a signals
    logic        rst_a, cyc_a, stb_a, we_a;
    logic [4:0]  adr_a;
    logic [7:0]  wdat_a, rdat_a, sdat_a;
    logic        ack_a, swe_a, berr_a;
    logic [1:0]  sstb_a, sack_a;
    logic [3:0]  sadr_a;
    logic [15:0] sdin_a;
    logic [7:0]  ecnt_a;
    logic [4:0]  eadr_a;

    // Instance b signals
    logic        rst_b, cyc_b, stb_b, we_b;
    logic [4:0]  adr_b;
    logic [7:0]  wdat_b, rdat_b, sdat_b;
    logic        ack_b, swe_b, berr_b;
    logic [1:0]  sstb_b, sack_b;
    logic [3:0]  sadr_b;
    logic [15:0] sdin_b;
    logic [7:0]  ecnt_b;
    logic [4:0]  eadr_b;

    wb_intercon_wdt #(
        .SEL_WIDTH (1), .ADR_WIDTH (5), .SLAVE_MASK (2'b11), .TIMEOUT (4), .ERR_DATA (8'hDE)
    ) dut_a (
        .wb_clk_i (clk), .wb_rst_i (rst_a), .wb_cyc_i (cyc_a), .wb_stb_i (stb_a),
        .wb_we_i (we_a), .wb_adr_i (adr_a), .wb_dat_i (wdat_a), .wb_dat_o (rdat_a),
        .wb_ack_o (ack_a), .s_stb_o (sstb_a), .s_we_o (swe_a), .s_adr_o (sadr_a),
        .s_dat_o (sdat_a), .s_dat_i (sdin_a), .s_ack_i (sack_a), .bus_err (berr_a),
        .err_count (ecnt_a), .err_adr (eadr_a)
    );

    wb_intercon_wdt #(
        .SEL_WIDTH (1), .ADR_WIDTH (5), .SLAVE_MASK (2'b01), .TIMEOUT (255), .ERR_DATA (8'hDE)
    ) dut_b (
        .wb_clk_i (clk), .wb_rst_i (rst_b), .wb_cyc_i (cyc_b), .wb_stb_i (stb_b),
        .wb_we_i (we_b), .wb_adr_i (adr_b), .wb_dat_i (wdat_b), .wb_dat_o (rdat_b),
        .wb_ack_o (ack_b), .s_stb_o (sstb_b), .s_we_o (swe_b), .s_adr_o (sadr_b),
        .s_dat_o (sdat_b), .s_dat_i (sdin_b), .s_ack_i (sack_b), .bus_err (berr_b),
        .err_count (ecnt_b), .err_adr (eadr_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; cyc_a = 1'b0; stb_a = 1'b0; we_a = 1'b0; adr_a = '0; wdat_a = '0;
        sdin_a = '0; sack_a = '0;
        rst_b = 1'b1; cyc_b = 1'b0; stb_b = 1'b0; we_b = 1'b0; adr_b = '0; wdat_b = '0;
        sdin_b = 16'h7777; sack_b = '0;
        tick(); tick();

        // Reset values
        check("rst_stb_a",  32'(sstb_a), 32'h0);
        check("rst_ack_a",  32'(ack_a),  32'h0);
        check("rst_err_a",  32'(berr_a), 32'h0);
        check("rst_dat_a",  32'(rdat_a), 32'h0);
        check("rst_ecnt_a", 32'(ecnt_a), 32'h0);
        check("rst_eadr_a", 32'(eadr_a), 32'h0);
        check("rst_sbus_a", 32'({swe_a, sadr_a, sdat_a}), 32'h0);
        check("rst_ecnt_b", 32'(ecnt_b), 32'h0);
        check("rst_stb_b",  32'(sstb_b), 32'h0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // Write to slave 0, ack in cycle 3
        cyc_a = 1'b1; stb_a = 1'b1; we_a = 1'b1; adr_a = 5'h03; wdat_a = 8'hA5;
        tick(); // cycle 1
        check("wr_stb_c1", 32'(sstb_a), 32'h1);
        check("wr_sadr",   32'(sadr_a), 32'h3);
        check("wr_sdat",   32'(sdat_a), 32'hA5);
        check("wr_swe",    32'(swe_a),  32'h1);
        check("wr_ack_c1", 32'(ack_a),  32'h0);
        tick(); // cycle 2
        check("wr_stb_c2", 32'(sstb_a), 32'h1);
        tick(); // cycle 3
        check("wr_stb_c3", 32'(sstb_a), 32'h1);
        sack_a = 2'b01;
        tick(); // cycle 4
        check("wr_ack_c4", 32'(ack_a),  32'h1);
        check("wr_stb_c4", 32'(sstb_a), 32'h0);
        check("wr_err_c4", 32'(berr_a), 32'h0);
        sack_a = 2'b00; cyc_a = 1'b0; stb_a = 1'b0; we_a = 1'b0;
        tick(); // cycle 5
        check("wr_ack_c5", 32'(ack_a), 32'h0);

        // Read from slave 1, immediate ack; slave 0 data must not leak; strobe held
        sdin_a = {8'h3C, 8'hFF}; sack_a = 2'b10;
        cyc_a = 1'b1; stb_a = 1'b1; adr_a = 5'h12;
        tick(); // cycle 1
        check("rd_stb_c1",  32'(sstb_a), 32'h2);
        check("rd_sadr",    32'(sadr_a), 32'h2);
        check("rd_ack_c1",  32'(ack_a),  32'h0);
        tick(); // cycle 2
        check("rd_ack_c2",  32'(ack_a),  32'h1);
        check("rd_dat_c2",  32'(rdat_a), 32'h3C);
        check("rd_stb_c2",  32'(sstb_a), 32'h0);
        tick(); // cycle 3, master still holding strobe
        check("rd_hold_ack", 32'(ack_a),  32'h0);
        check("rd_hold_stb", 32'(sstb_a), 32'h0);
        tick();
        check("rd_hold_stb2", 32'(sstb_a), 32'h0);
        cyc_a = 1'b0; stb_a = 1'b0; sack_a = 2'b00;
        tick();

        // Timeout on slave 0; ack from the non-selected slot is ignored
        sack_a = 2'b10; sdin_a = {8'h11, 8'h22};
        cyc_a = 1'b1; stb_a = 1'b1; adr_a = 5'h05;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("to_stb_high", 32'(sstb_a), 32'h1);
            check("to_no_ack",   32'(ack_a),  32'h0);
        end
        tick(); // cycle 5
        check("to_ack",  32'(ack_a),  32'h1);
        check("to_err",  32'(berr_a), 32'h1);
        check("to_dat",  32'(rdat_a), 32'hDE);
        check("to_ecnt", 32'(ecnt_a), 32'h1);
        check("to_eadr", 32'(eadr_a), 32'h05);
        check("to_stb",  32'(sstb_a), 32'h0);
        cyc_a = 1'b0; stb_a = 1'b0; sack_a = 2'b00;
        tick(); // cycle 6
        check("to_ack_c6", 32'(ack_a),  32'h0);
        check("to_err_c6", 32'(berr_a), 32'h0);
        sack_a = 2'b01; // late ack in cycle 7
        tick(); // cycle 7
        sack_a = 2'b00;
        tick(); // cycle 8
        check("late_ack",  32'(ack_a),  32'h0);
        check("late_err",  32'(berr_a), 32'h0);
        check("late_ecnt", 32'(ecnt_a), 32'h1);
        check("late_stb",  32'(sstb_a), 32'h0);

        // Slave ack on the final watchdog cycle wins
        sdin_a = {8'h00, 8'h5A};
        cyc_a = 1'b1; stb_a = 1'b1; adr_a = 5'h01;
        tick(); tick(); tick(); // cycles 1..3
        tick(); // cycle 4 (last strobe cycle)
        check("fin_stb_c4", 32'(sstb_a), 32'h1);
        sack_a = 2'b01;
        tick(); // cycle 5
        check("fin_ack",  32'(ack_a),  32'h1);
        check("fin_err",  32'(berr_a), 32'h0);
        check("fin_dat",  32'(rdat_a), 32'h5A);
        check("fin_ecnt", 32'(ecnt_a), 32'h1);
        sack_a = 2'b00; cyc_a = 1'b0; stb_a = 1'b0;
        tick();

        // Unpopulated slot on instance b, error counter saturation
        for (int i = 0; i < 256; i++) begin
            adr_b = {1'b1, 4'(i)};
            cyc_b = 1'b1; stb_b = 1'b1;
            tick(); // cycle 1
            if (i == 0) begin
                check("unp_ack",  32'(ack_b),  32'h1);
                check("unp_err",  32'(berr_b), 32'h1);
                check("unp_stb",  32'(sstb_b), 32'h0);
                check("unp_dat",  32'(rdat_b), 32'hDE);
                check("unp_ecnt", 32'(ecnt_b), 32'h1);
                check("unp_eadr", 32'(eadr_b), 32'h10);
            end
            if (i == 254) check("sat_ecnt_255", 32'(ecnt_b), 32'hFF);
            if (i == 255) begin
                check("sat_ecnt_hold", 32'(ecnt_b), 32'hFF);
                check("sat_err",       32'(berr_b), 32'h1);
                check("sat_eadr",      32'(eadr_b), 32'h1F);
            end
            cyc_b = 1'b0; stb_b = 1'b0;
            tick();
            if (i == 0) begin
                check("unp_ack_off", 32'(ack_b),  32'h0);
                check("unp_err_off", 32'(berr_b), 32'h0);
            end
        end

        // Reset pulsed mid-ACTIVE, then a normal access
        cyc_a = 1'b1; stb_a = 1'b1; adr_a = 5'h02; we_a = 1'b0;
        tick(); // cycle 1
        check("rst_mid_stb_c1", 32'(sstb_a), 32'h1);
        rst_a = 1'b1; cyc_a = 1'b0; stb_a = 1'b0;
        tick(); // reset edge
        check("rst_mid_stb",  32'(sstb_a), 32'h0);
        check("rst_mid_ack",  32'(ack_a),  32'h0);
        check("rst_mid_ecnt", 32'(ecnt_a), 32'h0);
        rst_a = 1'b0;
        tick();
        check("rst_mid_ack2", 32'(ack_a), 32'h0);
        sdin_a = {8'h99, 8'h00}; sack_a = 2'b10;
        cyc_a = 1'b1; stb_a = 1'b1; we_a = 1'b1; adr_a = 5'h13; wdat_a = 8'h42;
        tick(); // cycle 1
        check("post_stb",  32'(sstb_a), 32'h2);
        check("post_sadr", 32'(sadr_a), 32'h3);
        check("post_sdat", 32'(sdat_a), 32'h42);
        tick(); // cycle 2
        check("post_ack", 32'(ack_a),  32'h1);
        check("post_err", 32'(berr_a), 32'h0);
        cyc_a = 1'b0; stb_a = 1'b0; sack_a = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
